zx_ps2_keymatrix: RTL and testbench

PS/2 keyboard front end that feeds the ULA's port-0xFE read path. Receives PS/2 set-2 frames and decodes make/break sequences into a registered 8x5 ZX Spectrum key matrix. Presents the active-low 5-bit column result for the half-rows selected by A[15:8]. Also drives the F1/F11 hot-key levels used by the top level.

---
 rtl/zx_ps2_keymatrix.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_zx_ps2_keymatrix.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/zx_ps2_keymatrix.sv
// PS/2 set-2 keyboard receiver and decoder driving an 8x5 ZX Spectrum key matrix.
// Optional macro ZXKBD_CURSOR_KEYS_EN maps the E0-prefixed arrow keys to CAPS+5..8.
module zx_ps2_keymatrix #(
    parameter int TIMEOUT_CYCLES = 14000,
    parameter int SKIP_E1_BYTES  = 7
) (
    input  logic        CLK,
    input  logic        nRESET,
    input  logic        PS2_CLK,
    input  logic        PS2_DAT,
    input  logic [15:0] A,
    output logic [4:0]  KEYB,
    output logic        F11,
    output logic        F1,
    output logic        frame_err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SW = $clog2(SKIP_E1_BYTES + 1);

    typedef logic [7:0][4:0] mat_t;
    typedef enum logic [2:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK, S_SKIP} state_t;

    logic          r_clk_s1, r_clk_s2, r_clk_q, r_dat_s1, r_dat_s2;
    logic [9:0]    r_shift;
    logic [3:0]    r_bitcnt;
    logic [TW-1:0] r_idle;
    logic          r_strobe;
    logic [7:0]    r_byte;
    state_t        r_state, w_state_nxt;
    logic [SW-1:0] r_skip, w_skip_nxt;
    mat_t          r_matrix, w_eff;
    logic [5:0]    r_vk_n;
    logic          w_fall, w_frame_ok, w_make, w_brk, w_ext, w_unused_addr;
    logic [10:0]   w_shift;
    logic [6:0]    w_pos;
    logic [3:0]    w_vk;
    logic [4:0]    w_keyb;

    // Physical key position: {hit, row, column}
    function automatic logic [6:0] key_pos(input logic [7:0] c, input logic e);
        logic [6:0] p;
        p = 7'd0;
        if (e) begin
            case (c)
                8'h5A: p = {1'b1, 3'd6, 3'd0};
                8'h14: p = {1'b1, 3'd7, 3'd1};
                default: p = 7'd0;
            endcase
        end else begin
            case (c)
                8'h12, 8'h59: p = {1'b1, 3'd0, 3'd0};
                8'h1A: p = {1'b1, 3'd0, 3'd1}; 8'h22: p = {1'b1, 3'd0, 3'd2};
                8'h21: p = {1'b1, 3'd0, 3'd3}; 8'h2A: p = {1'b1, 3'd0, 3'd4};
                8'h1C: p = {1'b1, 3'd1, 3'd0}; 8'h1B: p = {1'b1, 3'd1, 3'd1};
                8'h23: p = {1'b1, 3'd1, 3'd2}; 8'h2B: p = {1'b1, 3'd1, 3'd3};
                8'h34: p = {1'b1, 3'd1, 3'd4};
                8'h15: p = {1'b1, 3'd2, 3'd0}; 8'h1D: p = {1'b1, 3'd2, 3'd1};
                8'h24: p = {1'b1, 3'd2, 3'd2}; 8'h2D: p = {1'b1, 3'd2, 3'd3};
                8'h2C: p = {1'b1, 3'd2, 3'd4};
                8'h16: p = {1'b1, 3'd3, 3'd0}; 8'h1E: p = {1'b1, 3'd3, 3'd1};
                8'h26: p = {1'b1, 3'd3, 3'd2}; 8'h25: p = {1'b1, 3'd3, 3'd3};
                8'h2E: p = {1'b1, 3'd3, 3'd4};
                8'h45: p = {1'b1, 3'd4, 3'd0}; 8'h46: p = {1'b1, 3'd4, 3'd1};
                8'h3E: p = {1'b1, 3'd4, 3'd2}; 8'h3D: p = {1'b1, 3'd4, 3'd3};
                8'h36: p = {1'b1, 3'd4, 3'd4};
                8'h4D: p = {1'b1, 3'd5, 3'd0}; 8'h44: p = {1'b1, 3'd5, 3'd1};
                8'h43: p = {1'b1, 3'd5, 3'd2}; 8'h3C: p = {1'b1, 3'd5, 3'd3};
                8'h35: p = {1'b1, 3'd5, 3'd4};
                8'h5A: p = {1'b1, 3'd6, 3'd0}; 8'h4B: p = {1'b1, 3'd6, 3'd1};
                8'h42: p = {1'b1, 3'd6, 3'd2}; 8'h3B: p = {1'b1, 3'd6, 3'd3};
                8'h33: p = {1'b1, 3'd6, 3'd4};
                8'h29: p = {1'b1, 3'd7, 3'd0}; 8'h14: p = {1'b1, 3'd7, 3'd1};
                8'h3A: p = {1'b1, 3'd7, 3'd2}; 8'h31: p = {1'b1, 3'd7, 3'd3};
                8'h32: p = {1'b1, 3'd7, 3'd4};
                default: p = 7'd0;
            endcase
        end
        return p;
    endfunction

    // Virtual key index: {hit, idx}; 0=Backspace 1=Esc 2..5=Left/Down/Up/Right
    function automatic logic [3:0] vk_idx(input logic [7:0] c, input logic e);
        logic [3:0] v;
        v = 4'd0;
        if (e) begin
            case (c)
`ifdef ZXKBD_CURSOR_KEYS_EN
                8'h6B: v = {1'b1, 3'd2};
                8'h72: v = {1'b1, 3'd3};
                8'h75: v = {1'b1, 3'd4};
                8'h74: v = {1'b1, 3'd5};
`endif
                default: v = 4'd0;
            endcase
        end else begin
            case (c)
                8'h66: v = {1'b1, 3'd0};
                8'h76: v = {1'b1, 3'd1};
                default: v = 4'd0;
            endcase
        end
        return v;
    endfunction

    // Pressed-key mask of a virtual key: 0 marks a key it holds down
    function automatic mat_t vk_mask(input logic [2:0] i);
        mat_t m;
        m = {8{5'b11111}};
        case (i)
            3'd0: begin m[0][0] = 1'b0; m[4][0] = 1'b0; end
            3'd1: begin m[0][0] = 1'b0; m[7][0] = 1'b0; end
            3'd2: begin m[0][0] = 1'b0; m[3][4] = 1'b0; end
            3'd3: begin m[0][0] = 1'b0; m[4][4] = 1'b0; end
            3'd4: begin m[0][0] = 1'b0; m[4][3] = 1'b0; end
            3'd5: begin m[0][0] = 1'b0; m[4][2] = 1'b0; end
            default: m = {8{5'b11111}};
        endcase
        return m;
    endfunction

    assign w_unused_addr = ^A[7:0];
    assign w_fall        = r_clk_q & ~r_clk_s2;
    assign w_shift       = {r_dat_s2, r_shift};
    assign w_frame_ok    = ~w_shift[0] & w_shift[10] & (^w_shift[9:1]);

    // Two-flop synchronisers plus delayed clock for edge detection
    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            {r_clk_s1, r_clk_s2, r_clk_q} <= 3'b111;
            {r_dat_s1, r_dat_s2}          <= 2'b11;
        end else begin
            {r_clk_s1, r_clk_s2, r_clk_q} <= {PS2_CLK, r_clk_s1, r_clk_s2};
            {r_dat_s1, r_dat_s2}          <= {PS2_DAT, r_dat_s1};
        end
    end

    // Frame receiver with idle timeout
    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            r_shift   <= 10'd0;
            r_bitcnt  <= 4'd0;
            r_idle    <= '0;
            r_strobe  <= 1'b0;
            r_byte    <= 8'd0;
            frame_err <= 1'b0;
        end else begin
            r_strobe  <= 1'b0;
            frame_err <= 1'b0;
            if (w_fall) begin
                r_idle  <= '0;
                r_shift <= w_shift[10:1];
                if (r_bitcnt == 4'd10) begin
                    r_bitcnt <= 4'd0;
                    if (w_frame_ok) begin
                        r_strobe <= 1'b1;
                        r_byte   <= w_shift[8:1];
                    end else begin
                        frame_err <= 1'b1;
                    end
                end else begin
                    r_bitcnt <= r_bitcnt + 4'd1;
                end
            end else begin
                if (r_idle != TW'(TIMEOUT_CYCLES))
                    r_idle <= r_idle + TW'(1);
                if (r_idle == TW'(TIMEOUT_CYCLES) && r_bitcnt != 4'd0) begin
                    r_bitcnt  <= 4'd0;
                    frame_err <= 1'b1;
                end
            end
        end
    end

    // Decoder state register
    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            r_state <= S_IDLE;
            r_skip  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_skip  <= w_skip_nxt;
        end
    end

    // Decoder next state and make/break events
    always_comb begin
        w_state_nxt = r_state;
        w_skip_nxt  = r_skip;
        w_make      = 1'b0;
        w_brk       = 1'b0;
        w_ext       = 1'b0;
        if (r_strobe) begin
            case (r_state)
                S_IDLE: begin
                    case (r_byte)
                        8'hE0: w_state_nxt = S_EXT;
                        8'hF0: w_state_nxt = S_BRK;
                        8'hE1: begin
                            w_state_nxt = S_SKIP;
                            w_skip_nxt  = SW'(SKIP_E1_BYTES);
                        end
                        8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: w_state_nxt = S_IDLE;
                        default: w_make = 1'b1;
                    endcase
                end
                S_EXT: begin
                    if (r_byte == 8'hF0) begin
                        w_state_nxt = S_EXT_BRK;
                    end else begin
                        w_make      = 1'b1;
                        w_ext       = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                S_BRK: begin
                    w_brk       = 1'b1;
                    w_state_nxt = S_IDLE;
                end
                S_EXT_BRK: begin
                    w_brk       = 1'b1;
                    w_ext       = 1'b1;
                    w_state_nxt = S_IDLE;
                end
                S_SKIP: begin
                    w_skip_nxt = r_skip - SW'(1);
                    if (r_skip <= SW'(1)) begin
                        w_skip_nxt  = '0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_SKIP;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    assign w_pos = key_pos(r_byte, w_ext);
    assign w_vk  = vk_idx(r_byte, w_ext);

    // Matrix, virtual-key flags and hot-key levels
    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            r_matrix <= {8{5'b11111}};
            r_vk_n   <= 6'b111111;
            F1       <= 1'b0;
            F11      <= 1'b0;
        end else if (w_make || w_brk) begin
            if (w_pos[6])
                r_matrix[w_pos[5:3]][w_pos[2:0]] <= w_brk;
            if (w_vk[3])
                r_vk_n[w_vk[2:0]] <= w_brk;
            if (!w_ext && r_byte == 8'h05)
                F1 <= w_make;
            if (!w_ext && r_byte == 8'h78)
                F11 <= w_make;
        end
    end

    // Effective matrix and half-row column read
    always_comb begin
        w_eff = r_matrix;
        for (int i = 0; i < 6; i++) begin
            if (!r_vk_n[i])
                w_eff = w_eff & vk_mask(3'(i));
            else
                w_eff = w_eff;
        end
        w_keyb = 5'b11111;
        for (int r = 0; r < 8; r++) begin
            if (!A[8+r])
                w_keyb = w_keyb & w_eff[r];
            else
                w_keyb = w_keyb;
        end
    end

    assign KEYB = w_keyb;
endmodule

// File: tb/tb_zx_ps2_keymatrix.sv
// Directed self-checking bench for zx_ps2_keymatrix.
module tb_zx_ps2_keymatrix;
    localparam int TIMEOUT_CYCLES = 14000;

    logic        CLK = 1'b0;
    logic        nRESET = 1'b0;
    logic        PS2_CLK = 1'b1;
    logic        PS2_DAT = 1'b1;
    logic [15:0] A = 16'hFFFE;
    logic [4:0]  KEYB;
    logic        F11, F1, frame_err;
    int          n_checks = 0;
    int          n_errors = 0;
    int          err_pulses = 0;
    int          base;

    zx_ps2_keymatrix #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .SKIP_E1_BYTES(7)) dut (
        .CLK(CLK), .nRESET(nRESET), .PS2_CLK(PS2_CLK), .PS2_DAT(PS2_DAT),
        .A(A), .KEYB(KEYB), .F11(F11), .F1(F1), .frame_err(frame_err)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) if (frame_err === 1'b1) err_pulses++;

    task automatic ps2_bit(input logic b);
        PS2_DAT = b;
        repeat (4) @(negedge CLK);
        PS2_CLK = 1'b0;
        repeat (8) @(negedge CLK);
        PS2_CLK = 1'b1;
        repeat (4) @(negedge CLK);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad);
        logic p;
        p = ~(^b) ^ bad;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(p);
        ps2_bit(1'b1);
        repeat (10) @(negedge CLK);
    endtask

    task automatic read_row(input logic [15:0] addr);
        @(negedge CLK);
        A = addr;
        #1;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        nRESET = 1'b0;
        repeat (3) @(negedge CLK);
        nRESET = 1'b1;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_reset();
        do_reset();
        read_row(16'h00FE);
        n_checks++; if (KEYB !== 5'b11111) begin n_errors++; $display("FAIL reset_keyb got %b want 11111", KEYB); end
        n_checks++; if (F1 !== 1'b0) begin n_errors++; $display("FAIL reset_f1 got %b want 0", F1); end
        n_checks++; if (F11 !== 1'b0) begin n_errors++; $display("FAIL reset_f11 got %b want 0", F11); end
        n_checks++; if (frame_err !== 1'b0) begin n_errors++; $display("FAIL reset_ferr got %b want 0", frame_err); end
    endtask

    task automatic test_make_break();
        send_byte(8'h1C, 1'b0);
        read_row(16'hFDFE);
        n_checks++; if (KEYB !== 5'b11110) begin n_errors++; $display("FAIL a_make got %b want 11110", KEYB); end
        read_row(16'hFEFE);
        n_checks++; if (KEYB !== 5'b11111) begin n_errors++; $display("FAIL a_other_row got %b want 11111", KEYB); end
        read_row(16'hFFFE);
        n_checks++; if (KEYB !== 5'b11111) begin n_errors++; $display("FAIL no_row got %b want 11111", KEYB); end
        send_byte(8'hF0, 1'b0); send_byte(8'h1C, 1'b0);
        read_row(16'hFDFE);
        n_checks++; if (KEYB !== 5'b11111) begin n_errors++; $display("FAIL a_break got %b want 11111", KEYB); end
        send_byte(8'h46, 1'b0);
        read_row(16'hEFFE);
        n_checks++; if (KEYB !== 5'b11101) begin n_errors++; $display("FAIL nine_make got %b want 11101", KEYB); end
        send_byte(8'hF0, 1'b0); send_byte(8'h46, 1'b0);
        send_byte(8'hE0, 1'b0); send_byte(8'h5A, 1'b0);
        read_row(16'hBFFE);
        n_checks++; if (KEYB !== 5'b11110) begin n_errors++; $display("FAIL ext_enter got %b want 11110", KEYB); end
        send_byte(8'hE0, 1'b0); send_byte(8'hF0, 1'b0); send_byte(8'h5A, 1'b0);
        read_row(16'h00FE);
        n_checks++; if (KEYB !== 5'b11111) begin n_errors++; $display("FAIL ext_enter_rel got %b want 11111", KEYB); end
    endtask

    task automatic test_multi_row();
        send_byte(8'h12, 1'b0); send_byte(8'h16, 1'b0);
        read_row(16'h00FE);
        n_checks++; if (KEYB !== 5'b11110) begin n_errors++; $display("FAIL all_rows got %b want 11110", KEYB); end
        read_row(16'hF7FE);
        n_checks++; if (KEYB !== 5'b11110) begin n_errors++; $display("FAIL row3_one got %b want 11110", KEYB); end
        send_byte(8'hF0, 1'b0); send_byte(8'h12, 1'b0);
        send_byte(8'hF0, 1'b0); send_byte(8'h16, 1'b0);
        read_row(16'h00FE);
        n_checks++; if (KEYB !== 5'b11111) begin n_errors++; $display("FAIL multi_rel got %b want 11111", KEYB); end
    endtask

    task automatic test_virtual();
        send_byte(8'h12, 1'b0); send_byte(8'h66, 1'b0);
        read_row(16'hFEFE);
        n_checks++; if (KEYB !== 5'b11110) begin n_errors++; $display("FAIL bs_row0 got %b want 11110", KEYB); end
        read_row(16'hEFFE);
        n_checks++; if (KEYB !== 5'b11110) begin n_errors++; $display("FAIL bs_row4 got %b want 11110", KEYB); end
        send_byte(8'hF0, 1'b0); send_byte(8'h66, 1'b0);
        read_row(16'hFEFE);
        n_checks++; if (KEYB !== 5'b11110) begin n_errors++; $display("FAIL bs_caps_kept got %b want 11110", KEYB); end
        read_row(16'hEFFE);
        n_checks++; if (KEYB !== 5'b11111) begin n_errors++; $display("FAIL bs_row4_rel got %b want 11111", KEYB); end
        send_byte(8'hF0, 1'b0); send_byte(8'h12, 1'b0);
        send_byte(8'h76, 1'b0); send_byte(8'h29, 1'b0);
        send_byte(8'hF0, 1'b0); send_byte(8'h76, 1'b0);
        read_row(16'h7FFE);
        n_checks++; if (KEYB !== 5'b11110) begin n_errors++; $display("FAIL esc_space_kept got %b want 11110", KEYB); end
        read_row(16'hFEFE);
        n_checks++; if (KEYB !== 5'b11111) begin n_errors++; $display("FAIL esc_caps_rel got %b want 11111", KEYB); end
        send_byte(8'hF0, 1'b0); send_byte(8'h29, 1'b0);
    endtask

    task automatic test_errors();
        base = err_pulses;
        send_byte(8'h1C, 1'b1);
        n_checks++; if (err_pulses !== base + 1) begin n_errors++; $display("FAIL parity_err pulses %0d want %0d", err_pulses - base, 1); end
        read_row(16'hFDFE);
        n_checks++; if (KEYB !== 5'b11111) begin n_errors++; $display("FAIL parity_nochg got %b want 11111", KEYB); end
        base = err_pulses;
        for (int i = 0; i < 5; i++) ps2_bit(i == 0 ? 1'b0 : 1'b1);
        repeat (TIMEOUT_CYCLES - 100) @(negedge CLK);
        n_checks++; if (err_pulses !== base) begin n_errors++; $display("FAIL early_timeout pulses %0d want 0", err_pulses - base); end
        repeat (300) @(negedge CLK);
        n_checks++; if (err_pulses !== base + 1) begin n_errors++; $display("FAIL timeout_err pulses %0d want 1", err_pulses - base); end
        send_byte(8'h29, 1'b0);
        read_row(16'h7FFE);
        n_checks++; if (KEYB !== 5'b11110) begin n_errors++; $display("FAIL after_timeout got %b want 11110", KEYB); end
        n_checks++; if (err_pulses !== base + 1) begin n_errors++; $display("FAIL spurious_err pulses %0d want 1", err_pulses - base); end
        send_byte(8'hF0, 1'b0); send_byte(8'h29, 1'b0);
    endtask

    task automatic test_skip_hotkeys();
        send_byte(8'hE1, 1'b0); send_byte(8'h14, 1'b0); send_byte(8'h77, 1'b0);
        send_byte(8'hE1, 1'b0); send_byte(8'hF0, 1'b0); send_byte(8'h14, 1'b0);
        send_byte(8'hF0, 1'b0); send_byte(8'h77, 1'b0);
        send_byte(8'h05, 1'b0);
        read_row(16'h7FFE);
        n_checks++; if (KEYB !== 5'b11111) begin n_errors++; $display("FAIL pause_sym got %b want 11111", KEYB); end
        n_checks++; if (F1 !== 1'b1) begin n_errors++; $display("FAIL f1_make got %b want 1", F1); end
        send_byte(8'hF0, 1'b0); send_byte(8'h05, 1'b0);
        n_checks++; if (F1 !== 1'b0) begin n_errors++; $display("FAIL f1_break got %b want 0", F1); end
        send_byte(8'h78, 1'b0);
        n_checks++; if (F11 !== 1'b1) begin n_errors++; $display("FAIL f11_make got %b want 1", F11); end
        send_byte(8'hF0, 1'b0); send_byte(8'h78, 1'b0);
        n_checks++; if (F11 !== 1'b0) begin n_errors++; $display("FAIL f11_break got %b want 0", F11); end
    endtask

    task automatic test_cursor();
        logic [4:0] exp0, exp4;
`ifdef ZXKBD_CURSOR_KEYS_EN
        exp0 = 5'b11110; exp4 = 5'b10111;
`else
        exp0 = 5'b11111; exp4 = 5'b11111;
`endif
        send_byte(8'hE0, 1'b0); send_byte(8'h75, 1'b0);
        read_row(16'hFEFE);
        n_checks++; if (KEYB !== exp0) begin n_errors++; $display("FAIL up_row0 got %b want %b", KEYB, exp0); end
        read_row(16'hEFFE);
        n_checks++; if (KEYB !== exp4) begin n_errors++; $display("FAIL up_row4 got %b want %b", KEYB, exp4); end
        send_byte(8'hE0, 1'b0); send_byte(8'hF0, 1'b0); send_byte(8'h75, 1'b0);
        read_row(16'h00FE);
        n_checks++; if (KEYB !== 5'b11111) begin n_errors++; $display("FAIL up_rel got %b want 11111", KEYB); end
        send_byte(8'h1C, 1'b0);
        read_row(16'hFDFE);
        n_checks++; if (KEYB !== 5'b11110) begin n_errors++; $display("FAIL post_ext got %b want 11110", KEYB); end
    endtask

    task automatic test_reset_midframe();
        for (int i = 0; i < 5; i++) ps2_bit(1'b0);
        do_reset();
        read_row(16'hFDFE);
        n_checks++; if (KEYB !== 5'b11111) begin n_errors++; $display("FAIL reset_clears got %b want 11111", KEYB); end
        send_byte(8'h1B, 1'b0);
        n_checks++; if (KEYB !== 5'b11101) begin n_errors++; $display("FAIL post_reset_frame got %b want 11101", KEYB); end
    endtask

    initial begin
        test_reset();
        test_make_break();
        test_multi_row();
        test_virtual();
        test_errors();
        test_skip_hotkeys();
        test_cursor();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
